framebuffer: RTL

Pixel store on the receiving end of the GPU's framebuffer write port (x, y, color, write strobe); sits between the GPU and the display controller. Stores FB_WIDTH×FB_HEIGHT 16-bit pixels in block RAM. Serves a raster-order scanout stream to the display side over a valid/ready handshake. Optionally double-buffered so the GPU draws into a back buffer while the front buffer is scanned.

---
 rtl/framebuffer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/framebuffer.sv
// framebuffer: GPU pixel store with a raster-order valid/ready scanout.
// Define FRAMEBUFFER_DOUBLE_BUFFER_EN for front/back buffers with swap.
module framebuffer #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wr_x,
  input  logic [15:0] wr_y,
  input  logic [15:0] wr_color,
  input  logic        wr_en,
  input  logic        scan_start,
  input  logic        scan_ready,
  output logic        scan_valid,
  output logic [15:0] scan_color,
  output logic [15:0] scan_x,
  output logic [15:0] scan_y,
  output logic        scan_last,
  input  logic        swap_req,
  output logic        swap_pending,
  output logic        front_sel
);

  localparam int PIX = FB_WIDTH * FB_HEIGHT;
  localparam int AW  = $clog2(PIX);
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int DEPTH = NBUF * PIX;
  localparam int MW    = $clog2(DEPTH);

  localparam logic [15:0] WID  = 16'(FB_WIDTH);
  localparam logic [15:0] HGT  = 16'(FB_HEIGHT);
  localparam logic [15:0] XMAX = 16'(FB_WIDTH - 1);
  localparam logic [15:0] YMAX = 16'(FB_HEIGHT - 1);

  typedef struct packed {
    logic [15:0] color;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic          issue;
  logic          start;
  logic          last_issue;
  logic          accept;
  logic [15:0]   rx;
  logic [15:0]   ry;
  logic [AW-1:0] rd_lin;
  logic [AW-1:0] wr_lin;
  logic [MW-1:0] rd_addr;
  logic [MW-1:0] wr_addr;
  logic          wr_ok;

  logic          in_flight;
  logic [15:0]   rd_data;
  logic [15:0]   rd_x;
  logic [15:0]   rd_y;
  logic          rd_last;
  pix_t          arr;

  pix_t          fifo [2];
  logic [1:0]    count;
  logic [1:0]    occ;
  logic          pop;
  logic          push;
  logic          slot;
  pix_t          head;

  // ---------------------------------------------------------------
  // Front/back selection
  // ---------------------------------------------------------------
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
  logic swap_apply;

  // A swap only lands while no frame is in flight, so a scan
  // always sees one buffer from first to last pixel.
  assign swap_apply = (state == IDLE) &&
                      (swap_pending || swap_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_apply) begin
      front_sel    <= ~front_sel;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  assign wr_addr = front_sel ? MW'(wr_lin)
                             : MW'(wr_lin) + MW'(PIX);
  assign rd_addr = front_sel ? MW'(rd_lin) + MW'(PIX)
                             : MW'(rd_lin);
`else
  logic swap_unused;

  assign swap_unused  = swap_req;
  assign swap_pending = 1'b0;
  assign front_sel    = 1'b0;
  assign wr_addr      = MW'(wr_lin);
  assign rd_addr      = MW'(rd_lin);
`endif

  // ---------------------------------------------------------------
  // Pixel RAM, read-first on a same-address collision
  // ---------------------------------------------------------------
  assign wr_ok = wr_en && (wr_x < WID) && (wr_y < HGT);

  assign wr_lin = AW'(32'(wr_y) * 32'(FB_WIDTH)
                      + 32'(wr_x));

  logic [15:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_color;
    end
    if (issue) begin
      rd_data <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------
  // Scanout FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (scan_start) begin
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (issue && last_issue) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && scan_last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    start = 1'b0;
    unique case (state)
      IDLE:    start = scan_start;
      SCAN:    issue = (occ < 2'd2);
      default: ;
    endcase
  end

  assign last_issue = (rx == XMAX) && (ry == YMAX);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      rx     <= 16'd0;
      ry     <= 16'd0;
      rd_lin <= '0;
    end else if (issue) begin
      rd_lin <= rd_lin + AW'(1);
      if (rx == XMAX) begin
        rx <= 16'd0;
        ry <= (ry == YMAX) ? 16'd0 : ry + 16'd1;
      end else begin
        rx <= rx + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Read pipeline and 2-entry output buffer
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= 1'b0;
      rd_x      <= 16'd0;
      rd_y      <= 16'd0;
      rd_last   <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        rd_x    <= rx;
        rd_y    <= ry;
        rd_last <= last_issue;
      end
    end
  end

  assign arr = '{color: rd_data, x: rd_x,
                 y: rd_y, last: rd_last};

  assign occ = {1'b0, in_flight} + count;

  // With an empty buffer the returning read is presented directly;
  // it is parked in the buffer only if the consumer stalls.
  assign scan_valid = (count != 2'd0) || in_flight;
  assign accept     = scan_valid && scan_ready;
  assign pop        = accept && (count != 2'd0);
  assign push       = in_flight &&
                      !(accept && (count == 2'd0));
  assign slot       = (count == 2'd1) && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      if (pop) begin
        fifo[0] <= fifo[1];
      end
      if (push) begin
        fifo[slot] <= arr;
      end
      count <= count - {1'b0, pop} + {1'b0, push};
    end
  end

  always_comb begin
    head = '0;
    unique case (1'b1)
      (count != 2'd0):             head = fifo[0];
      (count == 2'd0) && in_flight: head = arr;
      default: ;
    endcase
  end

  assign scan_color = head.color;
  assign scan_x     = head.x;
  assign scan_y     = head.y;
  assign scan_last  = head.last;

endmodule
